// File: rtl/pad_cell_output_driver_pkg.sv
// rtl/pad_cell_output_driver_pkg.sv - shared pad types, defaults and counter sizing helper
package pad_cell_output_driver_pkg;

  // Which edge of the die a pad sits on.
  typedef enum logic [1:0] {
    PAD_SIDE_N = 2'd0,
    PAD_SIDE_E = 2'd1,
    PAD_SIDE_S = 2'd2,
    PAD_SIDE_W = 2'd3
  } pad_side_e;

  // Output driver state: IDLE accepts requests, TURN waits out the dead time before enabling.
  typedef enum logic {
    DRV_IDLE = 1'b0,
    DRV_TURN = 1'b1
  } drive_state_e;

  localparam int DEFAULT_TURNAROUND_CYCLES = 2;
  localparam int DEFAULT_SETTLE_CYCLES     = 3;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pad_readback_sync.sv
// rtl/pad_readback_sync.sv - read-back synchronizer, settle counter and sticky contention flag
module pad_readback_sync
  import pad_cell_output_driver_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_in_i,
  input  logic pad_out_i,
  input  logic pad_oe_i,
  input  logic in_turn_i,
  input  logic clear_i,
  output logic mismatch_o
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);

  logic [1:0]    r_sync;
  logic [1:0]    r_hist_out;
  logic [1:0]    r_hist_oe;
  logic [SW-1:0] r_settle;
  logic          r_mismatch;

  logic w_change;
  logic w_set;

  // A change counts until it has had time to travel through both synchronizer stages,
  // so the settle window only opens once the read-back reflects the current drive.
  assign w_change = (pad_out_i != r_hist_out[0]) | (pad_oe_i != r_hist_oe[0]) |
                    (r_hist_out[0] != r_hist_out[1]) | (r_hist_oe[0] != r_hist_oe[1]);

  assign w_set = (r_settle == SETTLE_MAX) & pad_oe_i & (r_sync[1] != pad_out_i);

  assign mismatch_o = r_mismatch;

  // Two-flop synchronizer for the asynchronous pad input and history of the driven state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync     <= 2'b00;
      r_hist_out <= 2'b00;
      r_hist_oe  <= 2'b00;
    end else begin
      r_sync     <= {r_sync[0], pad_in_i};
      r_hist_out <= {r_hist_out[0], pad_out_i};
      r_hist_oe  <= {r_hist_oe[0], pad_oe_i};
    end
  end

  // Settle counter: cleared by a drive change or dead time, otherwise counts up and saturates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_settle <= '0;
    end else if (w_change || in_turn_i) begin
      r_settle <= '0;
    end else if (r_settle != SETTLE_MAX) begin
      r_settle <= r_settle + SW'(1);
    end
  end

  // Sticky contention flag; a new detection beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_set | (r_mismatch & ~clear_i);
    end
  end

endmodule

// File: rtl/pad_cell_output_driver.sv
// rtl/pad_cell_output_driver.sv - pad output driver with break-before-make and read-back check
module pad_cell_output_driver
  import pad_cell_output_driver_pkg::*;
#(
  parameter int PADATTR           = 16,
  parameter int TURNAROUND_CYCLES = DEFAULT_TURNAROUND_CYCLES,
  parameter int SETTLE_CYCLES     = DEFAULT_SETTLE_CYCLES
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               out_i,
  input  logic               oe_i,
  input  logic               od_mode_i,
  input  logic [PADATTR-1:0] attr_i,
  output logic               pad_out_o,
  output logic               pad_oe_o,
  output logic [PADATTR-1:0] pad_attributes_o,
  input  logic               pad_in_i,
  output logic               mismatch_o,
  input  logic               clear_i
);

  localparam int TW = cnt_width(TURNAROUND_CYCLES - 1);
  localparam bit HAS_TURN = (TURNAROUND_CYCLES > 0);
  localparam logic [TW-1:0] TURN_LOAD = HAS_TURN ? TW'(TURNAROUND_CYCLES - 1) : '0;

  drive_state_e       r_state;
  logic [TW-1:0]      r_turn_cnt;
  logic               r_out;
  logic               r_oe;
  logic [PADATTR-1:0] r_attr;

  drive_state_e       w_state_n;
  logic [TW-1:0]      w_turn_cnt_n;
  logic               w_out_n;
  logic               w_oe_n;
  logic [PADATTR-1:0] w_attr_n;

  logic w_eff_out;
  logic w_eff_oe;
  logic w_xfer;

  // Open-drain emulation only ever drives low; a high request becomes a release.
  assign w_eff_out = od_mode_i ? 1'b0 : out_i;
  assign w_eff_oe  = od_mode_i ? (oe_i & ~out_i) : oe_i;

  assign ready_o = (r_state == DRV_IDLE);
  assign w_xfer  = valid_i & ready_o;

  assign pad_out_o        = r_out;
  assign pad_oe_o         = r_oe;
  assign pad_attributes_o = r_attr;

  // Next-state and next-output decode: enabling waits out the dead time, releasing never does.
  always_comb begin
    w_state_n    = r_state;
    w_turn_cnt_n = r_turn_cnt;
    w_out_n      = r_out;
    w_oe_n       = r_oe;
    w_attr_n     = r_attr;
    case (r_state)
      DRV_IDLE: begin
        if (w_xfer) begin
          w_out_n  = w_eff_out;
          w_attr_n = attr_i;
          if (HAS_TURN && w_eff_oe && !r_oe) begin
            w_state_n    = DRV_TURN;
            w_turn_cnt_n = TURN_LOAD;
          end else begin
            w_oe_n = w_eff_oe;
          end
        end
      end
      DRV_TURN: begin
        if (r_turn_cnt == '0) begin
          w_oe_n    = 1'b1;
          w_state_n = DRV_IDLE;
        end else begin
          w_turn_cnt_n = r_turn_cnt - TW'(1);
        end
      end
      default: w_state_n = DRV_IDLE;
    endcase
  end

  // State and registered pad-facing outputs; reset drops any pending enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= DRV_IDLE;
      r_turn_cnt <= '0;
      r_out      <= 1'b0;
      r_oe       <= 1'b0;
      r_attr     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_turn_cnt <= w_turn_cnt_n;
      r_out      <= w_out_n;
      r_oe       <= w_oe_n;
      r_attr     <= w_attr_n;
    end
  end

  pad_readback_sync #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_readback (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pad_in_i  (pad_in_i),
    .pad_out_i (r_out),
    .pad_oe_i  (r_oe),
    .in_turn_i (r_state == DRV_TURN),
    .clear_i   (clear_i),
    .mismatch_o(mismatch_o)
  );

endmodule

// File: tb/tb_pad_cell_output_driver.sv
// tb/tb_pad_cell_output_driver.sv - self-checking bench for pad_cell_output_driver
module tb_pad_cell_output_driver;

  localparam int PA = 16;
  localparam int S  = 3;
  localparam int TA = 2;
  localparam int NC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, valid, out_r, oe_r, od, pad_in, clear;
  logic [PA-1:0] attr;
  logic          ready_a, pad_out_a, pad_oe_a, mm_a;
  logic          ready_b, pad_out_b, pad_oe_b, mm_b;
  logic [PA-1:0] attr_a, attr_b;

  pad_cell_output_driver #(.PADATTR(PA), .TURNAROUND_CYCLES(TA), .SETTLE_CYCLES(S)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_a), .out_i(out_r),
    .oe_i(oe_r), .od_mode_i(od), .attr_i(attr), .pad_out_o(pad_out_a), .pad_oe_o(pad_oe_a),
    .pad_attributes_o(attr_a), .pad_in_i(pad_in), .mismatch_o(mm_a), .clear_i(clear)
  );

  pad_cell_output_driver #(.PADATTR(PA), .TURNAROUND_CYCLES(0), .SETTLE_CYCLES(S)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_b), .out_i(out_r),
    .oe_i(oe_r), .od_mode_i(od), .attr_i(attr), .pad_out_o(pad_out_b), .pad_oe_o(pad_oe_b),
    .pad_attributes_o(attr_b), .pad_in_i(pad_in), .mismatch_o(mm_b), .clear_i(clear)
  );

  // Reference model: per instance, the visible pad state plus the cycle at which a pending
  // enable becomes visible; read-back is judged from per-cycle history arrays.
  int            tcfg[2];
  int            cyc;
  int            n_checks = 0;
  int            n_err = 0;
  logic          m_out[2], m_oe[2], m_mm[2];
  logic [PA-1:0] m_attr[2];
  int            m_en_at[2];
  logic          h_out[2][NC];
  logic          h_oe[2][NC];
  logic          h_turn[2][NC];
  logic          h_in[NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True when the drive has been unchanged long enough for the compare to be armed at cycle k.
  function automatic logic settle_hit(input int i, input int k);
    logic so, soe;
    if (k - S - 2 < 0) return 1'b0;
    for (int j = k - S; j < k; j++) if (h_turn[i][j]) return 1'b0;
    so  = h_out[i][k-1];
    soe = h_oe[i][k-1];
    for (int j = k - S - 2; j < k; j++)
      if (h_out[i][j] != so || h_oe[i][j] != soe) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic mdl_ready(input int i);
    return !(m_en_at[i] > cyc);
  endfunction

  // One clock cycle: compare all outputs at the falling edge, then advance the model.
  task automatic step();
    logic sync, rdy, eff_o, eff_oe, hit;
    @(negedge clk);
    chk($sformatf("c%0d a.ready", cyc), ready_a, mdl_ready(0));
    chk($sformatf("c%0d a.pad_out", cyc), pad_out_a, m_out[0]);
    chk($sformatf("c%0d a.pad_oe", cyc), pad_oe_a, m_oe[0]);
    chk($sformatf("c%0d a.attr", cyc), attr_a, m_attr[0]);
    chk($sformatf("c%0d a.mismatch", cyc), mm_a, m_mm[0]);
    chk($sformatf("c%0d b.ready", cyc), ready_b, mdl_ready(1));
    chk($sformatf("c%0d b.pad_out", cyc), pad_out_b, m_out[1]);
    chk($sformatf("c%0d b.pad_oe", cyc), pad_oe_b, m_oe[1]);
    chk($sformatf("c%0d b.attr", cyc), attr_b, m_attr[1]);
    chk($sformatf("c%0d b.mismatch", cyc), mm_b, m_mm[1]);
    sync = (cyc >= 2) ? h_in[cyc-2] : 1'b0;
    h_in[cyc] = rst_n ? pad_in : 1'b0;
    eff_o  = od ? 1'b0 : out_r;
    eff_oe = od ? (oe_r & ~out_r) : oe_r;
    for (int i = 0; i < 2; i++) begin
      rdy = mdl_ready(i);
      h_out[i][cyc]  = rst_n ? m_out[i] : 1'b0;
      h_oe[i][cyc]   = rst_n ? m_oe[i] : 1'b0;
      h_turn[i][cyc] = !rst_n || !rdy;
      if (!rst_n) begin
        m_out[i] = 1'b0; m_oe[i] = 1'b0; m_mm[i] = 1'b0; m_attr[i] = '0; m_en_at[i] = -1;
      end else begin
        hit = settle_hit(i, cyc) && m_oe[i] && (sync != m_out[i]);
        if (valid && rdy) begin
          m_out[i]  = eff_o;
          m_attr[i] = attr;
          if (eff_oe && !m_oe[i] && tcfg[i] > 0) m_en_at[i] = cyc + 1 + tcfg[i];
          else m_oe[i] = eff_oe;
        end
        if (m_en_at[i] == cyc + 1) m_oe[i] = 1'b1;
        m_mm[i] = hit | (m_mm[i] & ~clear);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic o, input logic e, input logic d,
                       input logic pin, input logic clr);
    valid = v; out_r = o; oe_r = e; od = d; pad_in = pin; clear = clr;
    attr = PA'($urandom);
  endtask

  int t_rise, t_mm;
  logic hold;

  initial begin
    tcfg[0] = TA; tcfg[1] = 0;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 1'b0; m_oe[i] = 1'b0; m_mm[i] = 1'b0; m_attr[i] = '0; m_en_at[i] = -1;
    end
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc = 0;
    step(); step();
    rst_n = 1'b1;
    chk("reset.ready", ready_a, 1'b1);
    chk("reset.pad_oe", pad_oe_a, 1'b0);
    chk("reset.mismatch", mm_a, 1'b0);
    step();

    // Enable from idle: dead time on A, immediate on B.
    drive(1, 1, 1, 0, 1, 0); step();
    valid = 1'b0;
    chk("tp1.out_t1", pad_out_a, 1'b1);
    chk("tp1.oe_t1", pad_oe_a, 1'b0);
    chk("tp1.ready_t1", ready_a, 1'b0);
    chk("tp6.oe_t1", pad_oe_b, 1'b1);
    chk("tp6.ready_t1", ready_b, 1'b1);
    step();
    chk("tp1.oe_t2", pad_oe_a, 1'b0);
    chk("tp1.ready_t2", ready_a, 1'b0);
    step();
    chk("tp1.oe_t3", pad_oe_a, 1'b1);
    chk("tp1.ready_t3", ready_a, 1'b1);

    // Release is immediate, re-enable repeats the dead time.
    drive(1, 1, 0, 0, 1, 0); step();
    chk("tp2.release", pad_oe_a, 1'b0);
    chk("tp2.ready", ready_a, 1'b1);
    drive(1, 0, 1, 0, 0, 0); step();
    valid = 1'b0;
    chk("tp2.dead1", pad_oe_a, 1'b0);
    step();
    step();
    chk("tp2.enable", pad_oe_a, 1'b1);

    // Open-drain: high is a release, low is an enable with dead time.
    drive(1, 1, 1, 1, 1, 0); step();
    chk("tp3.od_release", pad_oe_a, 1'b0);
    drive(1, 0, 1, 1, 0, 0); step();
    valid = 1'b0;
    step(); step();
    chk("tp3.od_enable", pad_oe_a, 1'b1);
    chk("tp3.od_out", pad_out_a, 1'b0);
    drive(1, 1, 1, 1, 1, 0); step();
    valid = 1'b0;
    chk("tp3.od_release2", pad_oe_a, 1'b0);
    step();

    // Contention: drive 1 while the pad reads 0.
    drive(1, 1, 1, 0, 0, 0); step();
    valid = 1'b0;
    t_rise = -1; t_mm = -1;
    for (int n = 0; n < 20 && t_mm < 0; n++) begin
      if (t_rise < 0 && pad_oe_a) t_rise = cyc;
      if (mm_a) t_mm = cyc;
      if (t_mm < 0) step();
    end
    chk("tp4.mm_seen", t_mm >= 0, 1'b1);
    chk("tp4.mm_delay", t_mm - t_rise, 2 + S + 1);
    pad_in = 1'b1; step(); step(); step();
    clear = 1'b1; step();
    clear = 1'b0;
    chk("tp4.cleared", mm_a, 1'b0);
    pad_in = 1'b0; clear = 1'b1;
    step(); step(); step(); step();
    chk("tp4.set_wins", mm_a, 1'b1);
    clear = 1'b0; step();

    // Reset in the middle of the dead time.
    drive(1, 1, 0, 0, 1, 0); step();
    drive(1, 1, 1, 0, 1, 0); step();
    valid = 1'b0;
    chk("tp5.in_turn", ready_a, 1'b0);
    rst_n = 1'b0; step();
    chk("tp5.oe", pad_oe_a, 1'b0);
    chk("tp5.out", pad_out_a, 1'b0);
    chk("tp5.ready", ready_a, 1'b1);
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step();

    // Randomized traffic; data held stable while A is not ready.
    hold = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (rst_n && $urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
      end
      if (!(hold && !mdl_ready(0))) begin
        valid = ($urandom_range(0, 2) != 0);
        out_r = 1'($urandom);
        oe_r  = ($urandom_range(0, 3) != 0);
        od    = ($urandom_range(0, 3) == 0);
        attr  = PA'($urandom);
      end
      hold   = valid;
      pad_in = m_out[0] ^ ($urandom_range(0, 7) == 0);
      clear  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
